// File: rtl/layer_sequencer_if.sv
// Handshake bundle around one layer sequencer: input stream from the previous
// layer, broadcast to the neurons, neuron results back, and the result stream
// to the next layer.
interface layer_sequencer_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH-1:0]             nrn_data;
    logic                              nrn_valid;
    logic [NUM_NEURONS-1:0]            nrn_outvalid;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              busy;
    logic                              err;

    // Sequencer side
    modport slave (
        input  in_data, in_valid, nrn_outvalid, nrn_out, out_ready,
        output in_ready, nrn_data, nrn_valid, out_data, out_valid, busy, err
    );

    // Environment side (previous layer, neurons, next layer)
    modport master (
        output in_data, in_valid, nrn_outvalid, nrn_out, out_ready,
        input  in_ready, nrn_data, nrn_valid, out_data, out_valid, busy, err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: buffers one input vector, broadcasts it to
// all neurons as a single gap-free valid burst, collects one result per neuron
// (with a timeout that zero-fills missing results) and streams the results out
// in neuron order.
module layer_sequencer #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    layer_sequencer_if.slave  io_bus
);
    localparam int WCW = $clog2(NUM_INPUTS) + 1;   // element counters
    localparam int AIW = $clog2(NUM_INPUTS);       // buffer address
    localparam int RIW = $clog2(NUM_NEURONS) + 1;  // result read index
    localparam int NIW = $clog2(NUM_NEURONS);      // result array address
    localparam int TCW = $clog2(TIMEOUT) + 1;      // wait counter

    localparam logic [WCW-1:0] WR_LAST   = WCW'(NUM_INPUTS - 1);
    localparam logic [WCW-1:0] RD_END    = WCW'(NUM_INPUTS);
    localparam logic [RIW-1:0] NRN_LAST  = RIW'(NUM_NEURONS - 1);
    localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_BCAST = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                                    r_state;
    logic [WCW-1:0]                            r_wr_cnt;
    logic [WCW-1:0]                            r_rd_cnt;
    logic                                      r_rd_vld;
    logic [DATA_WIDTH-1:0]                     r_rd_data;
    logic [TCW-1:0]                            r_wait_cnt;
    logic [RIW-1:0]                            r_rd_idx;
    logic [NUM_NEURONS-1:0]                    r_cap;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]    r_res;
    logic [DATA_WIDTH-1:0]                     r_buf [NUM_INPUTS];

    logic                                      r_in_ready;
    logic [DATA_WIDTH-1:0]                     r_nrn_data;
    logic                                      r_nrn_valid;
    logic [DATA_WIDTH-1:0]                     r_out_data;
    logic                                      r_out_valid;
    logic                                      r_busy;
    logic                                      r_err;

    logic [NUM_NEURONS-1:0]                    w_cap_next;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]    w_res_next;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]    w_res_final;
    logic                                      w_all_cap;
    logic                                      w_timeout;
    logic                                      w_fill_hs;
    logic                                      w_drain_hs;

    assign w_fill_hs  = io_bus.in_valid & r_in_ready;
    assign w_drain_hs = r_out_valid & io_bus.out_ready;
    assign w_all_cap  = &w_cap_next;
    assign w_timeout  = (r_wait_cnt == WAIT_LAST);

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.nrn_data  = r_nrn_data;
    assign io_bus.nrn_valid = r_nrn_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.busy      = r_busy;
    assign io_bus.err       = r_err;

    // Merge first-time neuron results of this cycle; w_res_final zeroes neurons still missing
    always_comb begin
        w_cap_next  = r_cap;
        w_res_next  = r_res;
        w_res_final = r_res;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (io_bus.nrn_outvalid[k] && !r_cap[k]) begin
                w_cap_next[k] = 1'b1;
                w_res_next[k] = io_bus.nrn_out[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_cap_next[k] = r_cap[k];
                w_res_next[k] = r_res[k];
            end
            if (w_cap_next[k]) begin
                w_res_final[k] = w_res_next[k];
            end else begin
                w_res_final[k] = {DATA_WIDTH{1'b0}};
            end
        end
    end

    // Input vector storage, one write per accepted element
    always_ff @(posedge clk) begin
        if (r_state == S_FILL && w_fill_hs) begin
            r_buf[r_wr_cnt[AIW-1:0]] <= io_bus.in_data;
        end
    end

    // Layer control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_wr_cnt    <= {WCW{1'b0}};
            r_rd_cnt    <= {WCW{1'b0}};
            r_rd_vld    <= 1'b0;
            r_rd_data   <= {DATA_WIDTH{1'b0}};
            r_wait_cnt  <= {TCW{1'b0}};
            r_rd_idx    <= {RIW{1'b0}};
            r_cap       <= {NUM_NEURONS{1'b0}};
            r_res       <= {(NUM_NEURONS*DATA_WIDTH){1'b0}};
            r_in_ready  <= 1'b1;
            r_nrn_data  <= {DATA_WIDTH{1'b0}};
            r_nrn_valid <= 1'b0;
            r_out_data  <= {DATA_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_fill_hs) begin
                        if (r_wr_cnt == WR_LAST) begin
                            r_wr_cnt   <= {WCW{1'b0}};
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_BCAST;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + WCW'(1);
                        end
                    end
                end

                // Read pipeline stage (r_rd_*) feeds the output stage one cycle
                // later, so the burst is contiguous and starts two edges after fill.
                S_BCAST: begin
                    r_nrn_valid <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_nrn_data <= r_rd_data;
                    end
                    if (r_rd_cnt != RD_END) begin
                        r_rd_data <= r_buf[r_rd_cnt[AIW-1:0]];
                        r_rd_vld  <= 1'b1;
                        r_rd_cnt  <= r_rd_cnt + WCW'(1);
                    end else begin
                        r_rd_vld <= 1'b0;
                        if (!r_rd_vld) begin
                            r_rd_cnt <= {WCW{1'b0}};
                            r_state  <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    r_cap <= w_cap_next;
                    if (w_all_cap || w_timeout) begin
                        r_res       <= w_res_final;
                        r_out_data  <= w_res_final[0];
                        r_out_valid <= 1'b1;
                        r_wait_cnt  <= {TCW{1'b0}};
                        r_state     <= S_DRAIN;
                        if (!w_all_cap) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_res      <= w_res_next;
                        r_wait_cnt <= r_wait_cnt + TCW'(1);
                    end
                end

                S_DRAIN: begin
                    if (w_drain_hs) begin
                        if (r_rd_idx == NRN_LAST) begin
                            r_out_valid <= 1'b0;
                            r_cap       <= {NUM_NEURONS{1'b0}};
                            r_rd_idx    <= {RIW{1'b0}};
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_FILL;
                        end else begin
                            r_rd_idx   <= r_rd_idx + RIW'(1);
                            r_out_data <= r_res[r_rd_idx[NIW-1:0] + NIW'(1)];
                        end
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed table of transactions,
// randomized transactions checked against a behavioural result model, and a
// hand-written reset-during-broadcast sequence.
module tb_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_sequencer_if #(.NUM_NEURONS(NN), .DATA_WIDTH(DW)) bus();

    layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );

    // mask[k] bit (t+1) = neuron k pulses outvalid in WAIT cycle t (t=-1: last beat cycle)
    typedef struct {
        logic [NI-1:0][DW-1:0] vec;
        logic [NN-1:0][DW-1:0] base;
        logic [NN-1:0][31:0]   mask;
        logic [7:0]            rdy;
        logic [NN-1:0]         junk;
        bit                    gaps;
        logic [NN-1:0][DW-1:0] exp_res;
        bit                    exp_err;
        int                    exp_done;
    } trans_t;

    int n_checks = 0;
    int n_errors = 0;
    bit err_sticky = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_neurons(input trans_t tr, input int t);
        for (int k = 0; k < NN; k++) begin
            if (t + 1 >= 0 && t + 1 < 32) bus.nrn_outvalid[k] = tr.mask[k][t+1];
            else                          bus.nrn_outvalid[k] = 1'b0;
            bus.nrn_out[k*DW +: DW] = (t < 0) ? 16'hDEAD : tr.base[k] + DW'(t);
        end
    endtask

    task automatic set_junk(input trans_t tr);
        bus.nrn_outvalid = tr.junk;
        bus.nrn_out      = {NN{16'hBAD0}};
    endtask

    // Result model: each neuron's first pulse inside the WAIT window wins;
    // any neuron without one is zeroed and raises the error.
    function automatic void model(inout trans_t tr);
        int first;
        tr.exp_err  = 1'b0;
        tr.exp_done = 0;
        for (int k = 0; k < NN; k++) begin
            first = -1;
            for (int t = TO - 1; t >= 0; t--) if (tr.mask[k][t+1]) first = t;
            if (first < 0) begin
                tr.exp_res[k] = 16'h0000;
                tr.exp_err    = 1'b1;
            end else begin
                tr.exp_res[k] = tr.base[k] + DW'(first);
                if (first > tr.exp_done) tr.exp_done = first;
            end
        end
        if (tr.exp_err) tr.exp_done = TO - 1;
    endfunction

    task automatic run_trans(input trans_t tr);
        int t, hs, c;
        bit stall;
        logic [DW-1:0] held;
        // fill
        for (int i = 0; i < NI; i++) begin
            set_junk(tr);
            if (tr.gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            chk("fill_busy", 32'(bus.busy), 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = tr.vec[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        // broadcast
        chk("bcast_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bcast_busy", 32'(bus.busy), 32'd1);
        chk("bcast_valid_e0", 32'(bus.nrn_valid), 32'd0);
        @(negedge clk);
        chk("bcast_valid_e1", 32'(bus.nrn_valid), 32'd0);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("bcast_valid", 32'(bus.nrn_valid), 32'd1);
            chk("bcast_data", 32'(bus.nrn_data), 32'(tr.vec[i]));
            chk("bcast_in_ready_beat", 32'(bus.in_ready), 32'd0);
            if (i == NI - 1) set_neurons(tr, -1);
            else             set_junk(tr);
            @(negedge clk);
        end
        chk("bcast_valid_fall", 32'(bus.nrn_valid), 32'd0);
        // wait
        for (t = 0; t <= tr.exp_done; t++) begin
            chk("wait_out_valid", 32'(bus.out_valid), 32'd0);
            set_neurons(tr, t);
            @(negedge clk);
        end
        // drain
        hs = 0; c = 0; stall = 1'b0; held = 16'h0000;
        while (hs < NN && c < 64) begin
            bus.out_ready = tr.rdy[c % 8];
            set_neurons(tr, t);
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            if (stall) chk("stall_hold", 32'(bus.out_data), 32'(held));
            if (bus.out_ready) begin
                chk("out_data", 32'(bus.out_data), 32'(tr.exp_res[hs]));
                hs++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                held  = bus.out_data;
            end
            @(negedge clk);
            c++; t++;
        end
        if (hs < NN) chk("drain_timeout", 32'(hs), 32'(NN));
        bus.out_ready    = 1'b0;
        bus.nrn_outvalid = {NN{1'b0}};
        err_sticky = err_sticky | tr.exp_err;
        chk("end_out_valid", 32'(bus.out_valid), 32'd0);
        chk("end_in_ready", 32'(bus.in_ready), 32'd1);
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_err", 32'(bus.err), 32'(err_sticky));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        trans_t tbl[6];
        trans_t tr;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 16'h0000;
        bus.nrn_outvalid = {NN{1'b0}}; bus.nrn_out = {(NN*DW){1'b0}};
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_nrn_valid", 32'(bus.nrn_valid), 32'd0);
        chk("rst_nrn_data", 32'(bus.nrn_data), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // simultaneous results
        tbl[0].vec = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tbl[0].base = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        tbl[0].mask = {32'h2, 32'h2, 32'h2};
        tbl[0].rdy = 8'hFF; tbl[0].junk = 3'b000; tbl[0].gaps = 1'b0;
        tbl[0].exp_res = {16'h0C0C, 16'h0B0B, 16'h0A0A}; tbl[0].exp_err = 1'b0; tbl[0].exp_done = 0;
        // staggered: n2 t=0, n1 t=2 and t=4, n0 t=6; junk outvalid during fill/bcast
        tbl[1].vec = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        tbl[1].base = {16'h3000, 16'h2000, 16'h1000};
        tbl[1].mask = {32'h2, 32'h28, 32'h80};
        tbl[1].rdy = 8'hFF; tbl[1].junk = 3'b111; tbl[1].gaps = 1'b1;
        tbl[1].exp_res = {16'h3000, 16'h2002, 16'h1006}; tbl[1].exp_err = 1'b0; tbl[1].exp_done = 6;
        // drain stall 1,0,0,1,1 and outvalid on the WAIT entry cycle
        tbl[2].vec = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        tbl[2].base = {16'h6000, 16'h5000, 16'h4000};
        tbl[2].mask = {32'h5, 32'h5, 32'h5};
        tbl[2].rdy = 8'h19; tbl[2].junk = 3'b101; tbl[2].gaps = 1'b0;
        tbl[2].exp_res = {16'h6001, 16'h5001, 16'h4001}; tbl[2].exp_err = 1'b0; tbl[2].exp_done = 1;
        // all captured on the very last WAIT cycle: no error
        tbl[3].vec = {16'h0F0F, 16'hF0F0, 16'h1234, 16'hABCD};
        tbl[3].base = {16'hC000, 16'hB000, 16'hA000};
        tbl[3].mask = {32'h10000, 32'h10000, 32'h10000};
        tbl[3].rdy = 8'hFF; tbl[3].junk = 3'b010; tbl[3].gaps = 1'b0;
        tbl[3].exp_res = {16'hC00F, 16'hB00F, 16'hA00F}; tbl[3].exp_err = 1'b0; tbl[3].exp_done = 15;
        // neuron1 too late -> timeout, zero result, sticky err
        tbl[4].vec = {16'h0101, 16'h0202, 16'h0303, 16'h0404};
        tbl[4].base = {16'h9000, 16'h8000, 16'h7000};
        tbl[4].mask = {32'h2, 32'h20000, 32'h10000};
        tbl[4].rdy = 8'hFF; tbl[4].junk = 3'b000; tbl[4].gaps = 1'b0;
        tbl[4].exp_res = {16'h9000, 16'h0000, 16'h700F}; tbl[4].exp_err = 1'b1; tbl[4].exp_done = 15;
        // normal vector after the error
        tbl[5].vec = {16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
        tbl[5].base = {16'h0003, 16'h0002, 16'h0001};
        tbl[5].mask = {32'h8, 32'h4, 32'h2};
        tbl[5].rdy = 8'hFF; tbl[5].junk = 3'b000; tbl[5].gaps = 1'b0;
        tbl[5].exp_res = {16'h0005, 16'h0003, 16'h0001}; tbl[5].exp_err = 1'b0; tbl[5].exp_done = 2;

        for (int i = 0; i < 6; i++) run_trans(tbl[i]);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NI; i++) tr.vec[i] = DW'($urandom);
            for (int k = 0; k < NN; k++) begin
                tr.base[k] = DW'($urandom);
                tr.mask[k] = $urandom & $urandom & $urandom;
            end
            tr.rdy  = 8'($urandom) | 8'h01;
            tr.junk = NN'($urandom);
            tr.gaps = 1'($urandom);
            model(tr);
            run_trans(tr);
        end

        // reset in the middle of the broadcast
        for (int i = 0; i < NI; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h00D1 + DW'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_beat0", 32'(bus.nrn_data), 32'h00D1);
        @(negedge clk);
        chk("rstmid_beat1", 32'(bus.nrn_data), 32'h00D2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_sticky = 1'b0;
        chk("rstmid_nrn_valid", 32'(bus.nrn_valid), 32'd0);
        chk("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("rstmid_nrn_valid2", 32'(bus.nrn_valid), 32'd0);
        run_trans(tbl[5]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
